// File: rtl/operand_fetch.sv
// ID-stage operand reader: register-file read addressing, writeback bypass,
// load-use hazard detection, ID/EX pipeline register and saturating stall count.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  output logic [ADDR_W-1:0] rf_read_register1,
  output logic [ADDR_W-1:0] rf_read_register2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_write_register,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [ADDR_W-1:0] ex_rs,
  output logic [ADDR_W-1:0] ex_rt,
  output logic [ADDR_W-1:0] ex_dest,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};

  logic              r_ex_valid, r_ex_reg_write, r_ex_mem_read;
  logic [ADDR_W-1:0] r_ex_rs, r_ex_rt, r_ex_dest;
  logic [DATA_W-1:0] r_ex_rs_data, r_ex_rt_data;
  logic [CNT_W-1:0]  r_stall_count;

  logic [DATA_W-1:0] w_rs_data, w_rt_data;
  logic              w_hazard;
  logic              w_refresh_rs, w_refresh_rt;

  // The register file commits at posedge, so a same-cycle write must be forwarded.
  function automatic logic [DATA_W-1:0] sel_operand(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] rf_data,
    input logic              wb_we,
    input logic [ADDR_W-1:0] wb_idx,
    input logic [DATA_W-1:0] wb_data
  );
    logic [DATA_W-1:0] res;
    if (idx == IDX_ZERO) begin
      res = {DATA_W{1'b0}};
    end else if (wb_we && (wb_idx == idx)) begin
      res = wb_data;
    end else begin
      res = rf_data;
    end
    return res;
  endfunction

  // Read addressing, bypassed operands and hazard / stall decode
  always_comb begin
    rf_read_register1 = id_rs;
    rf_read_register2 = id_rt;
    w_rs_data = sel_operand(id_rs, rf_read_data1, wb_reg_write, wb_write_register, wb_write_data);
    w_rt_data = sel_operand(id_rt, rf_read_data2, wb_reg_write, wb_write_register, wb_write_data);
    w_hazard  = id_valid && r_ex_valid && r_ex_mem_read && (r_ex_dest != IDX_ZERO) &&
                ((id_uses_rs && (r_ex_dest == id_rs)) || (id_uses_rt && (r_ex_dest == id_rt)));
    id_stall  = w_hazard || ex_hold;
    w_refresh_rs = wb_reg_write && (wb_write_register == r_ex_rs) && (r_ex_rs != IDX_ZERO);
    w_refresh_rt = wb_reg_write && (wb_write_register == r_ex_rt) && (r_ex_rt != IDX_ZERO);
  end

  // ID/EX register and stall counter: flush > hold > hazard bubble > load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid     <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_rs        <= IDX_ZERO;
      r_ex_rt        <= IDX_ZERO;
      r_ex_dest      <= IDX_ZERO;
      r_ex_rs_data   <= {DATA_W{1'b0}};
      r_ex_rt_data   <= {DATA_W{1'b0}};
      r_stall_count  <= {CNT_W{1'b0}};
    end else if (flush) begin
      r_ex_valid     <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
    end else if (ex_hold) begin
      // An older instruction retiring during the hold must not leave stale operands.
      if (w_refresh_rs) begin
        r_ex_rs_data <= wb_write_data;
      end
      if (w_refresh_rt) begin
        r_ex_rt_data <= wb_write_data;
      end
    end else if (w_hazard) begin
      r_ex_valid     <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      if (r_stall_count != CNT_MAX) begin
        r_stall_count <= r_stall_count + CNT_ONE;
      end
    end else begin
      r_ex_valid     <= id_valid;
      r_ex_reg_write <= id_reg_write;
      r_ex_mem_read  <= id_mem_read;
      r_ex_rs        <= id_rs;
      r_ex_rt        <= id_rt;
      r_ex_dest      <= id_dest;
      r_ex_rs_data   <= w_rs_data;
      r_ex_rt_data   <= w_rt_data;
    end
  end

  assign ex_valid     = r_ex_valid;
  assign ex_reg_write = r_ex_reg_write;
  assign ex_mem_read  = r_ex_mem_read;
  assign ex_rs        = r_ex_rs;
  assign ex_rt        = r_ex_rt;
  assign ex_dest      = r_ex_dest;
  assign ex_rs_data   = r_ex_rs_data;
  assign ex_rt_data   = r_ex_rt_data;
  assign stall_count  = r_stall_count;

endmodule
